// File: rtl/dot_acc_pkg.sv
// Shared types and default widths for the dot-product accumulate stage.
// Latency: n/a. Backpressure: n/a.
package dot_acc_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_PRODUCT_WIDTH = 2 * DEF_DATA_WIDTH;
    localparam int DEF_VECTOR_LEN    = 4;
    localparam int DEF_ACC_WIDTH     = DEF_PRODUCT_WIDTH + $clog2(DEF_VECTOR_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } dot_acc_state_t;

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Product-in / sum-out handshake bundle between the multiplier parent and the accumulator.
// Latency: n/a. Backpressure: valid/ready on both the product and the sum side.
interface dot_product_accumulator_if
    import dot_acc_pkg::*;
#(
    parameter int PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH
);
    logic                     start_i;
    logic [PRODUCT_WIDTH-1:0] product_i;
    logic                     product_valid_i;
    logic                     product_ready_o;
    logic [ACC_WIDTH-1:0]     sum_o;
    logic                     sum_valid_o;
    logic                     sum_ready_i;
    logic                     busy_o;

    modport master (
        output start_i, product_i, product_valid_i, sum_ready_i,
        input  product_ready_o, sum_o, sum_valid_o, busy_o
    );

    modport slave (
        input  start_i, product_i, product_valid_i, sum_ready_i,
        output product_ready_o, sum_o, sum_valid_o, busy_o
    );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums VECTOR_LEN signed products from the multiplier and presents the dot product.
// Latency: start + VECTOR_LEN accepted products -> sum valid the next cycle; one product/cycle best case.
// Backpressure: products accepted only in ACCUM; sum held in DONE until sum_ready_i.
module dot_product_accumulator
    import dot_acc_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int PRODUCT_WIDTH = 2 * DATA_WIDTH,
    parameter int VECTOR_LEN    = DEF_VECTOR_LEN,
    parameter int ACC_WIDTH     = PRODUCT_WIDTH + $clog2(VECTOR_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dot_product_accumulator_if.slave bus
);

    localparam int                   CNT_WIDTH = $clog2(VECTOR_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(VECTOR_LEN - 1);

    dot_acc_state_t       state_q;
    dot_acc_state_t       state_d;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] sum_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [ACC_WIDTH-1:0] product_ext;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 take;
    logic                 last;

    // Guard bits make the ACC_WIDTH add exact: sign-extend, never saturate.
    assign product_ext = {{(ACC_WIDTH - PRODUCT_WIDTH){bus.product_i[PRODUCT_WIDTH-1]}}, bus.product_i};
    assign acc_next    = acc_q + product_ext;
    assign take        = (state_q == ACCUM) && bus.product_valid_i;
    assign last        = take && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        bus.product_ready_o = 1'b0;
        bus.sum_valid_o     = 1'b0;
        bus.busy_o          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = ACCUM;
            end
            ACCUM: begin
                bus.product_ready_o = 1'b1;
                bus.busy_o          = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                bus.sum_valid_o = 1'b1;
                bus.busy_o      = 1'b1;
                if (bus.sum_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // sum_q is only written on the final product, so a reset mid-run never leaks a partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
        end else if (state_q == IDLE && bus.start_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (take) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + 1'b1;
            if (last) sum_q <= acc_next;
        end
    end

    assign bus.sum_o = sum_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomised and directed checks of dot_product_accumulator against a plain-arithmetic model.
module tb_dot_product_accumulator;

    localparam int DW  = 8;
    localparam int PW  = 16;
    localparam int VL  = 4;
    localparam int AW  = 18;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dot_product_accumulator_if #(.PRODUCT_WIDTH(PW), .ACC_WIDTH(AW)) bus ();

    dot_product_accumulator #(
        .DATA_WIDTH(DW), .PRODUCT_WIDTH(PW), .VECTOR_LEN(VL), .ACC_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_sum(input int p[VL]);
        int s = 0;
        for (int i = 0; i < VL; i++) s += p[i];
        return s;
    endfunction

    function automatic int sum_as_int();
        logic signed [AW-1:0] v;
        v = bus.sum_o;
        return int'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a run, feeds products with `gap` idle cycles between them and waits for sum_valid_o.
    // lat counts cycles from the start cycle to the cycle sum_valid_o is seen.
    task automatic drive_vector(input int p[VL], input int gap, output int lat);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        lat = 1;
        for (int i = 0; i < VL; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    lat++;
                end
            end
            bus.product_valid_i = 1'b1;
            bus.product_i       = PW'(p[i]);
            step();
            lat++;
            bus.product_valid_i = 1'b0;
            bus.product_i       = '0;
        end
        while (bus.sum_valid_o !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.product_i = '0;
        bus.product_valid_i = 1'b0;
        bus.sum_ready_i = 1'b1;
        #12;
        checks++;
        if (bus.sum_o !== '0 || bus.sum_valid_o !== 1'b0 || bus.product_ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state sum=%0h vld=%b rdy=%b busy=%b required 0/0/0/0",
                     bus.sum_o, bus.sum_valid_o, bus.product_ready_o, bus.busy_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_mixed_signs();
        int p[VL] = '{6, -20, 100, 1};
        int lat;
        bus.sum_ready_i = 1'b1;
        drive_vector(p, 0, lat);
        checks++;
        if (bus.sum_valid_o !== 1'b1 || sum_as_int() !== model_sum(p)) begin
            failures++;
            $display("FAIL mixed_sum vld=%b sum=%0d required 1/%0d", bus.sum_valid_o, sum_as_int(), model_sum(p));
        end
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL mixed_latency got=%0d required 5", lat);
        end
        step();
        checks++;
        if (bus.sum_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL mixed_one_cycle vld=%b busy=%b required 0/0", bus.sum_valid_o, bus.busy_o);
        end
    endtask

    task automatic test_extremes();
        int pmax[VL] = '{16384, 16384, 16384, 16384};
        int pmin[VL] = '{-16256, -16256, -16256, -16256};
        int lat;
        drive_vector(pmax, 0, lat);
        checks++;
        if (bus.sum_o !== 18'h10000) begin
            failures++;
            $display("FAIL extreme_pos sum=%0h required 10000", bus.sum_o);
        end
        step();
        drive_vector(pmin, 0, lat);
        checks++;
        if (sum_as_int() !== -65024) begin
            failures++;
            $display("FAIL extreme_neg sum=%0d required -65024", sum_as_int());
        end
        step();
    endtask

    task automatic test_gaps();
        int p[VL] = '{10, 20, 30, 40};
        int lat;
        drive_vector(p, 2, lat);
        checks++;
        if (bus.sum_valid_o !== 1'b1 || sum_as_int() !== 100) begin
            failures++;
            $display("FAIL gap_sum vld=%b sum=%0d required 1/100", bus.sum_valid_o, sum_as_int());
        end
        checks++;
        if (lat !== 1 + VL + 2 * (VL - 1)) begin
            failures++;
            $display("FAIL gap_latency got=%0d required %0d", lat, 1 + VL + 2 * (VL - 1));
        end
        step();
    endtask

    task automatic test_backpressure();
        int p[VL] = '{-7, 300, -1000, 55};
        int lat;
        int exp_sum;
        exp_sum = model_sum(p);
        bus.sum_ready_i = 1'b0;
        drive_vector(p, 0, lat);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.sum_valid_o !== 1'b1 || sum_as_int() !== exp_sum || bus.product_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d vld=%b sum=%0d prdy=%b required 1/%0d/0",
                         c, bus.sum_valid_o, sum_as_int(), bus.product_ready_o, exp_sum);
            end
            bus.start_i = c[0];
            step();
        end
        bus.start_i = 1'b0;
        bus.sum_ready_i = 1'b1;
        step();
        checks++;
        if (bus.sum_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || sum_as_int() !== exp_sum) begin
            failures++;
            $display("FAIL bp_release vld=%b busy=%b sum=%0d required 0/0/%0d",
                     bus.sum_valid_o, bus.busy_o, sum_as_int(), exp_sum);
        end
        step();
        checks++;
        if (bus.product_ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_start_not_queued prdy=%b busy=%b required 0/0", bus.product_ready_o, bus.busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int ones[VL] = '{1, 1, 1, 1};
        int lat;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.product_valid_i = 1'b1;
            bus.product_i = PW'(5000);
            step();
        end
        bus.product_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sum_valid_o !== 1'b0 || bus.product_ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.sum_o !== '0) begin
            failures++;
            $display("FAIL reset_mid vld=%b prdy=%b busy=%b sum=%0h required 0/0/0/0",
                     bus.sum_valid_o, bus.product_ready_o, bus.busy_o, bus.sum_o);
        end
        step();
        rst_n = 1'b1;
        step();
        drive_vector(ones, 0, lat);
        checks++;
        if (bus.sum_valid_o !== 1'b1 || sum_as_int() !== 4) begin
            failures++;
            $display("FAIL reset_fresh_run vld=%b sum=%0d required 1/4", bus.sum_valid_o, sum_as_int());
        end
        step();
    endtask

    task automatic test_back_to_back();
        int pa[VL] = '{1000, 2000, 3000, 4000};
        int pb[VL] = '{-3, -4, 5, 6};
        int lat;
        bus.sum_ready_i = 1'b1;
        drive_vector(pa, 0, lat);
        checks++;
        if (sum_as_int() !== model_sum(pa)) begin
            failures++;
            $display("FAIL b2b_first sum=%0d required %0d", sum_as_int(), model_sum(pa));
        end
        step();
        drive_vector(pb, 0, lat);
        checks++;
        if (bus.sum_valid_o !== 1'b1 || sum_as_int() !== model_sum(pb) || lat !== 5) begin
            failures++;
            $display("FAIL b2b_second vld=%b sum=%0d lat=%0d required 1/%0d/5",
                     bus.sum_valid_o, sum_as_int(), lat, model_sum(pb));
        end
        step();
    endtask

    task automatic test_random();
        int p[VL];
        int lat;
        int gap;
        int a;
        int b;
        bus.sum_ready_i = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < VL; i++) begin
                a = int'($urandom_range(255, 0)) - 128;
                b = int'($urandom_range(255, 0)) - 128;
                p[i] = a * b;
            end
            gap = int'($urandom_range(2, 0));
            drive_vector(p, gap, lat);
            checks++;
            if (bus.sum_valid_o !== 1'b1 || sum_as_int() !== model_sum(p) || lat !== 1 + VL + gap * (VL - 1)) begin
                failures++;
                $display("FAIL random_run n=%0d vld=%b sum=%0d lat=%0d required 1/%0d/%0d",
                         n, bus.sum_valid_o, sum_as_int(), lat, model_sum(p), 1 + VL + gap * (VL - 1));
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mixed_signs();
        test_extremes();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
